// File: rtl/exu_issue_buf_pkg.sv
// Shared widths, ALU function codes and the issue-entry layout for the execute-stage issue buffer.
package exu_issue_buf_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int ALU_FUNC_WIDTH = 4;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [ALU_FUNC_WIDTH-1:0] {
        ADD_S  = 4'd0,
        SUB_S  = 4'd1,
        AND_S  = 4'd2,
        OR_S   = 4'd3,
        XOR_S  = 4'd4,
        SLL_S  = 4'd5,
        SRL_S  = 4'd6,
        SRA_S  = 4'd7,
        SLT_S  = 4'd8,
        SLTU_S = 4'd9
    } alu_func_e;

    typedef struct packed {
        logic [ISA_WIDTH-1:0]      a;
        logic [ISA_WIDTH-1:0]      b;
        logic [ALU_FUNC_WIDTH-1:0] func;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } issue_entry_t;

    localparam int ENTRY_WIDTH = $bits(issue_entry_t);

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/exu_issue_buf_fifo.sv
// Register-based synchronous FIFO with wrap-bit pointers; the head entry is read straight from storage.
module exu_issue_buf_fifo #(
    parameter int DEPTH    = 2,
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata,
    output logic                full,
    output logic                empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[IDX_W-1:0]];

    // Power-of-two depth lets the index roll over naturally while the top bit toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[IDX_W-1:0]] <= wdata;
                wr_ptr                 <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/exu_issue_buf.sv
// Issue buffer between decoder and ALU; queues {a, b, func, rd} and returns ALU results to writeback.
// Optional output register after the ALU is enabled by defining EXU_ISSUE_RESULT_REG_EN.
module exu_issue_buf
    import exu_issue_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISA_WIDTH-1:0]      in_a,
    input  logic [ISA_WIDTH-1:0]      in_b,
    input  logic [ALU_FUNC_WIDTH-1:0] in_func,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    output logic [ISA_WIDTH-1:0]      alu_a,
    output logic [ISA_WIDTH-1:0]      alu_b,
    output logic [ALU_FUNC_WIDTH-1:0] alu_func,
    input  logic [ISA_WIDTH-1:0]      alu_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ISA_WIDTH-1:0]      out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd
);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("exu_issue_buf: DEPTH must be a power of two and at least 2");
    end

    issue_entry_t in_entry;
    issue_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         fifo_pop;

    assign in_entry = '{a: in_a, b: in_b, func: in_func, rd: in_rd};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    exu_issue_buf_fifo #(
        .DEPTH    (DEPTH),
        .DATA_LEN (ENTRY_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .wdata (in_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The ALU always sees the head entry, stale or not; out_valid qualifies it.
    assign alu_a    = head.a;
    assign alu_b    = head.b;
    assign alu_func = head.func;

`ifdef EXU_ISSUE_RESULT_REG_EN
    logic                      res_valid;
    logic [ISA_WIDTH-1:0]      res_result;
    logic [REG_ADDR_WIDTH-1:0] res_rd;

    // Refill the result register whenever it is empty or draining this cycle.
    assign fifo_pop = !fifo_empty && (!res_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_result <= '0;
            res_rd     <= '0;
        end else if (fifo_pop) begin
            res_valid  <= 1'b1;
            res_result <= alu_result;
            res_rd     <= head.rd;
        end else if (out_ready) begin
            res_valid  <= 1'b0;
        end
    end

    assign out_valid  = res_valid;
    assign out_result = res_result;
    assign out_rd     = res_rd;
`else
    assign out_valid  = !fifo_empty;
    assign out_result = alu_result;
    assign out_rd     = head.rd;
    assign fifo_pop   = out_valid && out_ready;
`endif

endmodule

// File: doc/exu_issue_buf.md
# exu_issue_buf

Execute-stage issue buffer between the instruction decoder and the ALU. It accepts decoded operations through a valid/ready handshake and queues them in a small FIFO. The head entry drives the ALU operand and function inputs from registers. The ALU result is returned to the writeback stage together with the destination register index through a second valid/ready handshake. It decouples decoder and writeback stalls from the combinational ALU.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the decoder offers an operation.
- in_ready  out  1  the buffer can accept an operation this cycle.
- in_a  in  ISA_WIDTH  operand a.
- in_b  in  ISA_WIDTH  operand b.
- in_func  in  ALU_FUNC_WIDTH  ALU function code.
- in_rd  in  REG_ADDR_WIDTH  destination register index.
- alu_a  out  ISA_WIDTH  to the ALU a input.
- alu_b  out  ISA_WIDTH  to the ALU b input.
- alu_func  out  ALU_FUNC_WIDTH  to the ALU func input.
- alu_result  in  ISA_WIDTH  from the ALU result output.
- out_valid  out  1  a result is offered to writeback.
- out_ready  in  1  writeback accepts the result.
- out_result  out  ISA_WIDTH  result value.
- out_rd  out  REG_ADDR_WIDTH  destination index for the result.

## Operation
- Push condition: in_valid && in_ready. The write pointer advances and the entry {a, b, func, rd} is stored.
- Pop condition: out_valid && out_ready.
- in_ready = !full. There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- alu_a, alu_b and alu_func always come from the head entry's storage registers. When the buffer is empty they show stale contents and out_valid is 0.
- Without a result register:
  - out_valid = !empty.
  - out_result = alu_result.
  - out_rd = head rd.
- Pointers are log2(DEPTH)+1 bits with a wrap bit.
  - empty when the pointers are equal.
  - full when the index bits are equal and the wrap bits differ.
  - Pointers wrap from DEPTH-1 to 0 with the wrap bit toggled.
- Simultaneous push and pop: the occupancy is unchanged and both pointers advance.
- Pushes while full are ignored because the handshake does not complete. The upstream must hold its data.
- The downstream must tolerate out_valid staying high while out_ready is low. out_result and out_rd stay stable until the pop.
- The block performs no arithmetic. Widths pass through unchanged.

## Timing
- Reset (synchronous, rst=1 at an edge):
  - Pointers go to 0 and storage is cleared.
  - in_ready=1, out_valid=0.
  - alu_a=0, alu_b=0, alu_func=0, out_result=alu_result, out_rd=0.
- Reset asserted mid-operation discards all queued entries at that edge, including a push or pop in the same cycle.
- Latency without the result register: a push at edge N gives out_valid=1 after edge N, in cycle N+1.
- Throughput: one operation per cycle when out_ready is held at 1.
- A full buffer sees in_ready fall in the cycle after the filling push.

## Configuration
- EXU_ISSUE_RESULT_REG_EN:
  - Defined: adds one output register {result, rd, valid} after the ALU.
    - The head is popped into the register when the register is empty or is being drained in the same cycle.
    - out_valid, out_result and out_rd come from the register.
    - Latency becomes 2 cycles and full throughput is kept.
    - Capacity is DEPTH+1.
    - Reset clears the register to 0 and its valid to 0.
  - Undefined: behaviour as in Operation, with combinational out_result and latency 1.

## Structure
- ISA_WIDTH, ALU_FUNC_WIDTH, REG_ADDR_WIDTH (new, value 5) and the ALU function codes (ADD_S, SUB_S, etc.) live in the shared config.v header. They are not redefined locally.
- One natural sub-module is sync_fifo (DEPTH, DATA_LEN), which stores {a, b, func, rd}.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset, then push a=5, b=3, func=ADD_S, rd=7 with out_ready=1 → the next cycle gives out_valid=1, out_result=8, out_rd=7, then empty.
- out_ready=0, DEPTH=2, push three ops (ADD_S 1+1, SUB_S 9-4, XOR 6^3) → in_ready=0 after the second push, the third is held by upstream. Then out_ready=1 → results 2, 5, 5 in order, and in_ready returns to 1.
- Continuous streaming with in_valid=1 and out_ready=1 for 10 ops with AND a=0xF0, b=0x3C → one result 0x30 per cycle with no bubbles, and the pointers wrap correctly.
- Full buffer with simultaneous push attempt and pop → the pop completes, the push is rejected, and occupancy becomes DEPTH-1.
- rst=1 asserted while the buffer is full → next cycle out_valid=0, in_ready=1 and alu_func=0. The old entries never appear.
- With EXU_ISSUE_RESULT_REG_EN: push OR a=0x1, b=0x2 → out_result=0x3 two cycles after the push. Back-to-back ops keep one result per cycle.
